// File: rtl/vec_alu_seq.sv
// Multi-cycle vector ALU execute stage: latches an issued operation, works through LANES elements
// per cycle, then presents the assembled vector as a one-cycle register-file write.
module vec_alu_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ELEMENTS   = 8,
    parameter int unsigned LANES      = 2,
    parameter int unsigned VLEN       = DATA_WIDTH * ELEMENTS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid_i,
    output logic                      issue_ready_o,
    input  logic [2:0]                op_i,
    input  logic [$clog2(ELEMENTS):0] vl_i,
    input  logic [VLEN-1:0]           vs1_data_i,
    input  logic [VLEN-1:0]           vs2_data_i,
    input  logic [4:0]                vd_addr_i,
    output logic                      busy_o,
    output logic                      vregw_en_o,
    output logic [4:0]                vrd_addr_o,
    output logic [VLEN-1:0]           vrd_data_o
);
    localparam int unsigned GROUPS = ELEMENTS / LANES;
    localparam int unsigned GW     = DATA_WIDTH * LANES;
    localparam int unsigned CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned VLW    = $clog2(ELEMENTS) + 1;
    localparam int unsigned SHW    = $clog2(DATA_WIDTH);

    if (ELEMENTS % LANES != 0) begin : g_lanes_check
        $error("ELEMENTS must be a multiple of LANES");
    end
    if (VLEN != DATA_WIDTH * ELEMENTS) begin : g_vlen_check
        $error("VLEN must equal DATA_WIDTH * ELEMENTS");
    end

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [VLW-1:0]    vl_q, vl_d;
    logic [4:0]        vd_q, vd_d;
    logic [VLEN-1:0]   vs1_q, vs1_d, vs2_q, vs2_d;
    logic [VLEN-1:0]   res_q, res_d;
    logic [4:0]        vrd_addr_q, vrd_addr_d;
    logic [VLEN-1:0]   vrd_data_q, vrd_data_d;

    logic [GW-1:0]         group_res;
    logic [VLEN-1:0]       res_next;
    logic [DATA_WIDTH-1:0] lane_a, lane_b, lane_r;
    logic                  accept;

    assign issue_ready_o = (state_q == StIdle);
    assign busy_o        = (state_q != StIdle);
    assign vregw_en_o    = (state_q == StWb);
    assign vrd_addr_o    = vrd_addr_q;
    assign vrd_data_o    = vrd_data_q;
    assign accept        = issue_valid_i && issue_ready_o;

    // Operands shift down one group per cycle, so the current group always sits in the low bits.
    always_comb begin
        group_res = '0;
        lane_a    = '0;
        lane_b    = '0;
        lane_r    = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_a = vs2_q[l*DATA_WIDTH +: DATA_WIDTH];
            lane_b = vs1_q[l*DATA_WIDTH +: DATA_WIDTH];
            case (op_q)
                3'd0:    lane_r = lane_a + lane_b;
                3'd1:    lane_r = lane_a - lane_b;
                3'd2:    lane_r = lane_a & lane_b;
                3'd3:    lane_r = lane_a | lane_b;
                3'd4:    lane_r = lane_a ^ lane_b;
                3'd5:    lane_r = lane_a << lane_b[SHW-1:0];
                3'd6:    lane_r = lane_a >> lane_b[SHW-1:0];
                default: lane_r = ($signed(lane_a) > $signed(lane_b)) ? lane_a : lane_b;
            endcase
            if ((32'(cnt_q) * LANES + 32'(l)) >= 32'(vl_q)) begin
                lane_r = '0;
            end
            group_res[l*DATA_WIDTH +: DATA_WIDTH] = lane_r;
        end
    end

    // Results enter at the top; after GROUPS shifts group 0 lands in the low bits.
    assign res_next = (res_q >> GW) | (VLEN'(group_res) << (VLEN - GW));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        vl_d       = vl_q;
        vd_d       = vd_q;
        vs1_d      = vs1_q;
        vs2_d      = vs2_q;
        res_d      = res_q;
        vrd_addr_d = vrd_addr_q;
        vrd_data_d = vrd_data_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d    = op_i;
                    vl_d    = (vl_i > VLW'(ELEMENTS)) ? VLW'(ELEMENTS) : vl_i;
                    vd_d    = vd_addr_i;
                    vs1_d   = vs1_data_i;
                    vs2_d   = vs2_data_i;
                    cnt_d   = '0;
                    state_d = StExec;
                end
            end
            StExec: begin
                vs1_d = vs1_q >> GW;
                vs2_d = vs2_q >> GW;
                res_d = res_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(GROUPS - 1)) begin
                    cnt_d      = '0;
                    vrd_addr_d = vd_q;
                    vrd_data_d = res_next;
                    state_d    = StWb;
                end
            end
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= '0;
            vl_q       <= '0;
            vd_q       <= '0;
            vs1_q      <= '0;
            vs2_q      <= '0;
            res_q      <= '0;
            vrd_addr_q <= '0;
            vrd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            vl_q       <= vl_d;
            vd_q       <= vd_d;
            vs1_q      <= vs1_d;
            vs2_q      <= vs2_d;
            res_q      <= res_d;
            vrd_addr_q <= vrd_addr_d;
            vrd_data_q <= vrd_data_d;
        end
    end

endmodule

// File: tb/tb_vec_alu_seq.sv
// Self-checking bench for vec_alu_seq: directed cases plus random operations against an
// element-wise reference model.
module tb_vec_alu_seq;
    localparam int DW = 32;
    localparam int EL = 8;
    localparam int LN = 2;
    localparam int VL = DW * EL;

    typedef logic [VL-1:0] vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [2:0]  op_i;
    logic [3:0]  vl_i;
    vec_t        vs1_data_i;
    vec_t        vs2_data_i;
    logic [4:0]  vd_addr_i;
    logic        busy_o;
    logic        vregw_en_o;
    logic [4:0]  vrd_addr_o;
    vec_t        vrd_data_o;

    int checks    = 0;
    int failures  = 0;
    int wb_pulses = 0;

    always #5 clk = ~clk;

    vec_alu_seq #(
        .DATA_WIDTH(DW),
        .ELEMENTS  (EL),
        .LANES     (LN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid_i(issue_valid_i),
        .issue_ready_o(issue_ready_o),
        .op_i         (op_i),
        .vl_i         (vl_i),
        .vs1_data_i   (vs1_data_i),
        .vs2_data_i   (vs2_data_i),
        .vd_addr_i    (vd_addr_i),
        .busy_o       (busy_o),
        .vregw_en_o   (vregw_en_o),
        .vrd_addr_o   (vrd_addr_o),
        .vrd_data_o   (vrd_data_o)
    );

    always @(negedge clk) if (vregw_en_o === 1'b1) wb_pulses++;

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // result[i] = vs2[i] op vs1[i]; elements at or beyond the clamped vl are zero.
    function automatic vec_t model(input logic [2:0] op, input int vl, input vec_t s1,
                                   input vec_t s2);
        vec_t r;
        int n;
        logic [DW-1:0] x, y, e;
        r = '0;
        n = (vl > EL) ? EL : vl;
        for (int i = 0; i < n; i++) begin
            x = s2[i*DW +: DW];
            y = s1[i*DW +: DW];
            case (op)
                3'd0: e = x + y;
                3'd1: e = x - y;
                3'd2: e = x & y;
                3'd3: e = x | y;
                3'd4: e = x ^ y;
                3'd5: e = x << (y % DW);
                3'd6: e = x >> (y % DW);
                default: e = ($signed(x) > $signed(y)) ? x : y;
            endcase
            r[i*DW +: DW] = e;
        end
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < EL; i++) v[i*DW +: DW] = $urandom;
        return v;
    endfunction

    task automatic scramble();
        op_i       = 3'($urandom);
        vl_i       = 4'($urandom);
        vs1_data_i = rand_vec();
        vs2_data_i = rand_vec();
        vd_addr_i  = 5'($urandom);
    endtask

    // Called just after a falling edge with the block idle; returns #1 after the accepting edge.
    task automatic start_op(input logic [2:0] op, input logic [3:0] vl, input vec_t s1,
                            input vec_t s2, input logic [4:0] vd);
        check("ready_idle", issue_ready_o, 1'b1);
        op_i          = op;
        vl_i          = vl;
        vs1_data_i    = s1;
        vs2_data_i    = s2;
        vd_addr_i     = vd;
        issue_valid_i = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the write strobe and checks latency, payload, pulse width and hold.
    task automatic finish_op(input vec_t exp, input logic [4:0] vd);
        bit seen;
        seen = 1'b0;
        for (int n = 1; n <= 10 && !seen; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("busy_exec", busy_o, 1'b1);
                check("ready_exec", issue_ready_o, 1'b0);
            end
            if (vregw_en_o === 1'b1) begin
                seen = 1'b1;
                check("wb_latency", n, 5);
                check("wb_addr", vrd_addr_o, vd);
                check("wb_data", vrd_data_o, exp);
            end
        end
        check("wb_seen", seen, 1'b1);
        @(negedge clk);
        check("wb_single", vregw_en_o, 1'b0);
        check("ready_after", issue_ready_o, 1'b1);
        check("hold_addr", vrd_addr_o, vd);
        check("hold_data", vrd_data_o, exp);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [3:0] vl, input vec_t s1,
                          input vec_t s2, input logic [4:0] vd);
        start_op(op, vl, s1, s2, vd);
        issue_valid_i = 1'b0;
        scramble();
        finish_op(model(op, int'(vl), s1, s2), vd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t a, b, e, ea;
        logic [2:0] oa;
        logic [3:0] la;
        logic [4:0] da;
        int p;

        rst           = 1'b1;
        issue_valid_i = 1'b0;
        scramble();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", issue_ready_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_wen", vregw_en_o, 1'b0);
        check("rst_addr", vrd_addr_o, '0);
        check("rst_data", vrd_data_o, '0);
        rst = 1'b0;

        // ADD: vs2 = 1..8, vs1 = 0x10 each
        for (int i = 0; i < EL; i++) begin
            a[i*DW +: DW] = 32'h10;
            b[i*DW +: DW] = DW'(i + 1);
            e[i*DW +: DW] = DW'(32'h11 + i);
        end
        start_op(3'd0, 4'd8, a, b, 5'd3);
        issue_valid_i = 1'b0;
        scramble();
        finish_op(e, 5'd3);

        a = rand_vec(); b = rand_vec();
        a[31:0] = 32'd1; b[31:0] = 32'd0;
        run_op(3'd1, 4'd8, a, b, 5'd7);
        check("sub_wrap", vrd_data_o[31:0], 32'hFFFF_FFFF);

        a = rand_vec(); b = rand_vec();
        a[63:32] = 32'd5; b[63:32] = 32'hFFFF_FFFF;
        run_op(3'd7, 4'd8, a, b, 5'd9);
        check("max_signed", vrd_data_o[63:32], 32'd5);

        a = rand_vec(); b = rand_vec();
        a[31:0] = 32'h21; b[31:0] = 32'h3;
        run_op(3'd5, 4'd8, a, b, 5'd1);
        check("sll_mask", vrd_data_o[31:0], 32'h6);

        a = rand_vec(); b = rand_vec();
        a[31:0] = 32'd31; b[31:0] = 32'h8000_0000;
        run_op(3'd6, 4'd8, a, b, 5'd2);
        check("srl_logical", vrd_data_o[31:0], 32'h1);

        // Tail handling and vl clamping on all-ones XOR zero
        a = '0; b = '1;
        e = '0; e[3*DW-1:0] = '1;
        start_op(3'd4, 4'd3, a, b, 5'd4);
        issue_valid_i = 1'b0;
        scramble();
        finish_op(e, 5'd4);
        e = '1;
        start_op(3'd4, 4'd12, a, b, 5'd5);
        issue_valid_i = 1'b0;
        scramble();
        finish_op(e, 5'd5);
        e = '0;
        start_op(3'd4, 4'd0, a, b, 5'd0);
        issue_valid_i = 1'b0;
        scramble();
        finish_op(e, 5'd0);

        // Back-to-back with valid held: second op offered during the first's EXEC
        oa = 3'd0; la = 4'd8; da = 5'd11;
        a = rand_vec(); b = rand_vec();
        ea = model(oa, int'(la), a, b);
        start_op(oa, la, a, b, da);
        op_i = 3'd1; vl_i = 4'd6; vd_addr_i = 5'd12;
        vs1_data_i = rand_vec(); vs2_data_i = rand_vec();
        e = model(op_i, int'(vl_i), vs1_data_i, vs2_data_i);
        finish_op(ea, da);
        @(posedge clk);
        #1;
        issue_valid_i = 1'b0;
        scramble();
        finish_op(e, 5'd12);

        // Reset during the third EXEC cycle aborts without a write
        start_op(3'd0, 4'd8, rand_vec(), rand_vec(), 5'd13);
        issue_valid_i = 1'b0;
        scramble();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        p   = wb_pulses;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", issue_ready_o, 1'b1);
        check("abort_busy", busy_o, 1'b0);
        check("abort_addr", vrd_addr_o, '0);
        check("abort_data", vrd_data_o, '0);
        repeat (6) @(negedge clk);
        check("abort_no_wb", wb_pulses, p);
        run_op(3'd3, 4'd8, rand_vec(), rand_vec(), 5'd14);

        for (int t = 0; t < 40; t++) begin
            run_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), rand_vec(), rand_vec(),
                   5'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vec_alu_seq.md
Name: vec_alu_seq

Overview:
- Multi-cycle vector execute stage.
- Sits directly downstream of the vector register-file read ports and upstream of its write port.
- Accepts an issued operation with both full-width source operands and processes LANES elements per cycle.
- Returns the assembled result as a single-cycle write request (vd address, data, enable) to the register file.

Parameters:
DATA_WIDTH, 32, element width in bits
ELEMENTS, 8, elements per vector register
LANES, 2, elements processed per EXEC cycle; ELEMENTS % LANES == 0 (elaboration error otherwise)
VLEN, DATA_WIDTH*ELEMENTS, vector register width in bits

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
issue_valid_i  input  1  operation offered
issue_ready_o  output  1  block can accept an operation
op_i  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MAX (signed)
vl_i  input  $clog2(ELEMENTS)+1  active element count
vs1_data_i  input  VLEN  source operand 1 (register-file rs1 read data)
vs2_data_i  input  VLEN  source operand 2 (register-file rs2 read data)
vd_addr_i  input  5  destination register
busy_o  output  1  operation in flight (EXEC or WB)
vregw_en_o  output  1  write strobe to register file
vrd_addr_o  output  5  write address
vrd_data_o  output  VLEN  write data

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- Reset values: state IDLE, issue_ready_o=1, busy_o=0, vregw_en_o=0, vrd_addr_o=0, vrd_data_o=0, element counter 0.
- Handshake: an issue is accepted on a rising edge with issue_valid_i && issue_ready_o.
  - issue_ready_o is high only in IDLE (registered state decode).
  - vs1, vs2, op, vd and vl are latched at acceptance; inputs are don't-care afterwards.
- FSM:
  - IDLE -> EXEC on accept.
  - EXEC processes elements [k*LANES, k*LANES+LANES-1] for k = 0..ELEMENTS/LANES-1, one group per cycle; after the last group -> WB.
  - WB: vregw_en_o=1 for exactly one cycle, with vrd_addr_o=latched vd and vrd_data_o=full result; then -> IDLE.
- Latency: accept at edge T; EXEC occupies ELEMENTS/LANES cycles; vregw_en_o high in cycle T+ELEMENTS/LANES+1. Defaults: 4 EXEC cycles, write strobe in cycle T+5.
- Throughput: next accept no earlier than the edge ending WB, i.e. one operation per ELEMENTS/LANES+2 cycles.
- busy_o = (state != IDLE).
- Element arithmetic, result[i] = vs2[i] op vs1[i]:
  - ADD/SUB wrap modulo 2^DATA_WIDTH; SUB is vs2-vs1.
  - Shifts use vs1[i][$clog2(DATA_WIDTH)-1:0]; SRL is logical.
  - MAX compares as two's-complement.
- Active and tail elements:
  - vl is clamped to ELEMENTS at latch time.
  - Elements i >= vl are tail and are written as 0.
  - vl=0 still runs the full sequence and writes an all-zero vector.
- vd=0: the write is still issued; the register file discards it. The block does not special-case vd=0.
- vregw_en_o is 0 in every state except WB. vrd_addr_o and vrd_data_o hold their last WB values outside WB.
- Reset mid-operation (EXEC or WB): abort in the reset cycle. No write is issued and all reset values apply on the next cycle.
- issue_valid_i while busy: ignored. The upstream stage must hold the operation until issue_ready_o.

Test Plan:
- Reset then ADD: vl=8, vs2 elements 1..8, vs1 all 0x10, vd=3 -> ready drops after accept; vregw_en_o is a single pulse 5 cycles after accept with addr 3 and data elements 0x11..0x18.
- SUB wrap and MAX signed: vs2[0]=0, vs1[0]=1 -> 0xFFFFFFFF. MAX with vs2[1]=0xFFFFFFFF, vs1[1]=5 -> 5.
- SLL with vs1[0]=0x21 -> shift by 1. SRL of 0x80000000 by 31 -> 1.
- Tail: vl=3 with XOR of all-ones operands against 0 -> elements 0..2 = 0xFFFFFFFF, elements 3..7 = 0. vl=12 clamps to 8.
- Back-to-back: issue_valid_i held high with two operations -> second accepted exactly 6 cycles after the first. Inputs changed during EXEC do not affect the first result.
- Reset asserted in 3rd EXEC cycle -> no vregw_en_o pulse; issue_ready_o=1 on the next cycle; a new op then completes correctly.
